// File: rtl/pd_pkg.sv
// pd5 shared types: access sizes, M-stage state, E->M bundle.
// Also holds data-memory map defaults and address checks.
package pd_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] DEF_MEM_BASE  = 32'h0100_0000;
  localparam int unsigned DEF_MEM_DEPTH = 1048576;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ALU   = 2'd1,
    BUSY  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        mem_en;
    logic        mem_rw;
    logic [1:0]  size;
    logic        uns;
  } ex_mem_t;

  // Size 11 is never legal, so it is reported here too.
  function automatic logic bad_align(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic r;
    r = 1'b1;
    if (sz == SZ_B)      r = 1'b0;
    else if (sz == SZ_H) r = lo[0];
    else if (sz == SZ_W) r = |lo;
    return r;
  endfunction

  // 33-bit compare: base+depth may sit at 2^32.
  function automatic logic in_range(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [32:0] depth
  );
    logic [32:0] lo_b;
    logic [32:0] hi_b;
    lo_b = {1'b0, base};
    hi_b = lo_b + depth;
    return ({1'b0, a} >= lo_b) &&
           ({1'b0, a} < hi_b);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data, misalign flag, load extract.
// Ports: size, addr_lo, st_data, rdata, uns -> be, wdata, misalign, ld_data.
module lsu_align
  import pd_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  input  logic        uns,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  assign misalign = bad_align(size, addr_lo);
  assign sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be      = 4'b0000;
    wdata   = st_data;
    ld_data = sh;
    unique case (1'b1)
      (size == SZ_B): begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
        ld_data = uns ?
          {24'b0, sh[7:0]} :
          {{24{sh[7]}}, sh[7:0]};
      end
      (size == SZ_H): begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
        ld_data = uns ?
          {16'b0, sh[15:0]} :
          {{16{sh[15]}}, sh[15:0]};
      end
      (size == SZ_W): begin
        be = 4'b1111;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// pd5 M stage: latches E, runs dmem req/ack, extends loads, feeds W.
// Ports: E-side *_x + m_ready, dmem_* handshake, pc_m/alu_m probes, W-side *_w.
module mem_stage
  import pd_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  output logic        m_ready,
  input  logic [31:0] pc_x,
  input  logic [31:0] alu_x,
  input  logic [31:0] rs2_x,
  input  logic [4:0]  rd_x,
  input  logic        wb_en_x,
  input  logic        mem_en_x,
  input  logic        mem_rw_x,
  input  logic [1:0]  access_size_x,
  input  logic        unsigned_x,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_m,
  output logic [31:0] alu_m,
  output logic        w_valid,
  output logic [31:0] pc_w,
  output logic        write_enable_w,
  output logic [4:0]  rd_w,
  output logic [31:0] data_rd_w,
  output logic        fault_w
);

  localparam logic [32:0] DEPTH33 = 33'(MEM_DEPTH);

  mem_state_t state_q;
  mem_state_t state_d;
  ex_mem_t    m_q;

  logic        fault_x;
  logic        fault_m;
  logic        misalign_m;
  logic        m_done;
  logic        accept;
  logic        is_load_m;
  logic [3:0]  be_m;
  logic [31:0] wdata_m;
  logic [31:0] ld_m;

  lsu_align u_align (
    .size     (m_q.size),
    .addr_lo  (m_q.alu[1:0]),
    .st_data  (m_q.rs2),
    .rdata    (dmem_rdata),
    .uns      (m_q.uns),
    .be       (be_m),
    .wdata    (wdata_m),
    .misalign (misalign_m),
    .ld_data  (ld_m)
  );

  // Fault must be known at accept to pick BUSY vs ALU.
  assign fault_x = mem_en_x &&
    (bad_align(access_size_x, alu_x[1:0]) ||
     !in_range(alu_x, MEM_BASE, DEPTH33));

  assign fault_m = m_q.mem_en &&
    (misalign_m ||
     !in_range(m_q.alu, MEM_BASE, DEPTH33));

  assign is_load_m = m_q.mem_en && !m_q.mem_rw && !fault_m;

  // An ack outside BUSY never completes anything.
  assign m_done = (state_q == ALU) ||
                  ((state_q == BUSY) && dmem_ack);
  assign m_ready = (state_q == EMPTY) || m_done;
  assign accept  = x_valid && m_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (m_ready) begin
      if (!x_valid)
        state_d = EMPTY;
      else if (mem_en_x && !fault_x)
        state_d = BUSY;
      else
        state_d = ALU;
    end
  end

  always_comb begin
    dmem_req   = (state_q == BUSY);
    dmem_we    = dmem_req && m_q.mem_rw;
    dmem_addr  = dmem_req ? {m_q.alu[31:2], 2'b00} : 32'h0;
    dmem_wdata = (dmem_req && m_q.mem_rw) ? wdata_m : 32'h0;
    dmem_be    = dmem_req ? be_m : 4'b0000;
    pc_m       = m_q.pc;
    alu_m      = m_q.alu;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_q <= '0;
    end else if (accept) begin
      m_q <= '{
        pc:     pc_x,
        alu:    alu_x,
        rs2:    rs2_x,
        rd:     rd_x,
        wb_en:  wb_en_x,
        mem_en: mem_en_x,
        mem_rw: mem_rw_x,
        size:   access_size_x,
        uns:    unsigned_x
      };
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_valid        <= 1'b0;
      pc_w           <= 32'h0;
      write_enable_w <= 1'b0;
      rd_w           <= 5'd0;
      data_rd_w      <= 32'h0;
      fault_w        <= 1'b0;
    end else if (m_done) begin
      w_valid <= 1'b1;
      pc_w    <= m_q.pc;
      rd_w    <= m_q.rd;
      fault_w <= fault_m;
      write_enable_w <= m_q.wb_en && !fault_m &&
                        (m_q.rd != 5'd0) &&
                        !(m_q.mem_en && m_q.mem_rw);
      data_rd_w <= is_load_m ? ld_m : m_q.alu;
    end else begin
      w_valid        <= 1'b0;
      write_enable_w <= 1'b0;
      fault_w        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, faults, stalls, reset.
// Expected values are hand-computed constants.
module tb_mem_stage;
  import pd_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid;
  logic        m_ready;
  logic [31:0] pc_x;
  logic [31:0] alu_x;
  logic [31:0] rs2_x;
  logic [4:0]  rd_x;
  logic        wb_en_x;
  logic        mem_en_x;
  logic        mem_rw_x;
  logic [1:0]  access_size_x;
  logic        unsigned_x;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] pc_m;
  logic [31:0] alu_m;
  logic        w_valid;
  logic [31:0] pc_w;
  logic        write_enable_w;
  logic [4:0]  rd_w;
  logic [31:0] data_rd_w;
  logic        fault_w;

  int n_run  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clock          (clock),
    .reset          (reset),
    .x_valid        (x_valid),
    .m_ready        (m_ready),
    .pc_x           (pc_x),
    .alu_x          (alu_x),
    .rs2_x          (rs2_x),
    .rd_x           (rd_x),
    .wb_en_x        (wb_en_x),
    .mem_en_x       (mem_en_x),
    .mem_rw_x       (mem_rw_x),
    .access_size_x  (access_size_x),
    .unsigned_x     (unsigned_x),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .pc_m           (pc_m),
    .alu_m          (alu_m),
    .w_valid        (w_valid),
    .pc_w           (pc_w),
    .write_enable_w (write_enable_w),
    .rd_w           (rd_w),
    .data_rd_w      (data_rd_w),
    .fault_w        (fault_w)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic op(
    input logic        mem,
    input logic        rw,
    input logic [1:0]  sz,
    input logic        u,
    input logic        wb,
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [4:0]  rd
  );
    x_valid       = 1'b1;
    mem_en_x      = mem;
    mem_rw_x      = rw;
    access_size_x = sz;
    unsigned_x    = u;
    wb_en_x       = wb;
    pc_x          = pc;
    alu_x         = a;
    rs2_x         = d;
    rd_x          = rd;
  endtask

  task automatic idle;
    x_valid       = 1'b0;
    mem_en_x      = 1'b0;
    mem_rw_x      = 1'b0;
    access_size_x = SZ_W;
    unsigned_x    = 1'b0;
    wb_en_x       = 1'b0;
    pc_x          = 32'h0;
    alu_x         = 32'h0;
    rs2_x         = 32'h0;
    rd_x          = 5'd0;
  endtask

  task automatic ack(input logic a, input logic [31:0] r);
    dmem_ack   = a;
    dmem_rdata = r;
  endtask

  // Single load with zero-wait ack; checks retired data.
  task automatic load1(
    input string       tag,
    input logic [1:0]  sz,
    input logic        u,
    input logic [31:0] a,
    input logic [31:0] raw,
    input logic [31:0] exp
  );
    op(1'b1, 1'b0, sz, u, 1'b1, 32'h104, a, 32'h0, 5'd5);
    tick;
    idle;
    ack(1'b1, raw);
    #1;
    chk({tag, "_req"}, 32'(dmem_req), 32'h1);
    tick;
    ack(1'b0, 32'h0);
    chk({tag, "_data"}, data_rd_w, exp);
    chk({tag, "_we"}, 32'(write_enable_w), 32'h1);
    chk({tag, "_rd"}, 32'(rd_w), 32'd5);
  endtask

  logic [1:0]  f_sz [5];
  logic [31:0] f_ad [5];
  logic        f_ex [5];

  initial begin
    f_sz[0] = SZ_W;  f_ad[0] = 32'h00FF_FFFC; f_ex[0] = 1'b1;
    f_sz[1] = SZ_W;  f_ad[1] = 32'h0110_0000; f_ex[1] = 1'b1;
    f_sz[2] = SZ_W;  f_ad[2] = 32'h0100_0002; f_ex[2] = 1'b1;
    f_sz[3] = 2'b11; f_ad[3] = 32'h0100_0000; f_ex[3] = 1'b1;
    f_sz[4] = SZ_W;  f_ad[4] = 32'h010F_FFFC; f_ex[4] = 1'b0;

    idle;
    ack(1'b0, 32'h0);
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_wv", 32'(w_valid), 32'h0);
    chk("rst_we", 32'(write_enable_w), 32'h0);
    chk("rst_flt", 32'(fault_w), 32'h0);
    chk("rst_rdy", 32'(m_ready), 32'h1);
    chk("rst_pcw", pc_w, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);

    // SW, zero-wait ack
    op(1'b1, 1'b1, SZ_W, 1'b0, 1'b0,
       32'h100, 32'h0100_0004, 32'hDEAD_BEEF, 5'd0);
    #1;
    chk("sw_rdy0", 32'(m_ready), 32'h1);
    tick;
    idle;
    ack(1'b1, 32'h0);
    #1;
    chk("sw_req", 32'(dmem_req), 32'h1);
    chk("sw_we", 32'(dmem_we), 32'h1);
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_wd", dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_ad", dmem_addr, 32'h0100_0004);
    chk("sw_rdy", 32'(m_ready), 32'h1);
    tick;
    ack(1'b0, 32'h0);
    chk("sw_wv", 32'(w_valid), 32'h1);
    chk("sw_wen", 32'(write_enable_w), 32'h0);
    chk("sw_pcw", pc_w, 32'h100);

    // loads with extraction
    load1("lb", SZ_B, 1'b0, 32'h0100_0003,
          32'h80FF_1234, 32'hFFFF_FF80);
    load1("lbu", SZ_B, 1'b1, 32'h0100_0003,
          32'h80FF_1234, 32'h0000_0080);
    load1("lh", SZ_H, 1'b0, 32'h0100_0002,
          32'h80FF_1234, 32'hFFFF_80FF);
    load1("lhu", SZ_H, 1'b1, 32'h0100_0000,
          32'h80FF_9234, 32'h0000_9234);

    // SB lane 3
    op(1'b1, 1'b1, SZ_B, 1'b0, 1'b1,
       32'h110, 32'h0100_0003, 32'h0000_00A5, 5'd4);
    tick;
    idle;
    ack(1'b1, 32'h0);
    #1;
    chk("sb_be", 32'(dmem_be), 32'h8);
    chk("sb_wd", dmem_wdata, 32'hA5A5_A5A5);
    tick;
    ack(1'b0, 32'h0);
    chk("sb_wen", 32'(write_enable_w), 32'h0);

    // SH upper half
    op(1'b1, 1'b1, SZ_H, 1'b0, 1'b0,
       32'h114, 32'h0100_0006, 32'h1234_BEEF, 5'd0);
    tick;
    idle;
    ack(1'b1, 32'h0);
    #1;
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wd", dmem_wdata, 32'hBEEF_BEEF);
    tick;
    ack(1'b0, 32'h0);

    // misaligned LH
    op(1'b1, 1'b0, SZ_H, 1'b0, 1'b1,
       32'h120, 32'h0100_0001, 32'h0, 5'd6);
    tick;
    idle;
    #1;
    chk("lhm_req", 32'(dmem_req), 32'h0);
    chk("lhm_rdy", 32'(m_ready), 32'h1);
    tick;
    chk("lhm_wv", 32'(w_valid), 32'h1);
    chk("lhm_flt", 32'(fault_w), 32'h1);
    chk("lhm_we", 32'(write_enable_w), 32'h0);
    chk("lhm_pcw", pc_w, 32'h120);

    // range / size boundaries
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, f_sz[i], 1'b0, 1'b1,
         32'h130, f_ad[i], 32'h0, 5'd3);
      tick;
      idle;
      ack(1'b1, 32'h1122_3344);
      #1;
      chk("bnd_req", 32'(dmem_req), 32'(!f_ex[i]));
      tick;
      ack(1'b0, 32'h0);
      chk("bnd_flt", 32'(fault_w), 32'(f_ex[i]));
      chk("bnd_wv", 32'(w_valid), 32'h1);
    end

    // LW with 3 wait cycles, ADD held behind it
    op(1'b1, 1'b0, SZ_W, 1'b0, 1'b1,
       32'h200, 32'h0100_0008, 32'h0, 5'd7);
    tick;
    op(1'b0, 1'b0, SZ_W, 1'b0, 1'b1,
       32'h204, 32'h0000_1234, 32'h0, 5'd8);
    ack(1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lw_req", 32'(dmem_req), 32'h1);
      chk("lw_rdy", 32'(m_ready), 32'h0);
      chk("lw_wv", 32'(w_valid), 32'h0);
      chk("lw_pcm", pc_m, 32'h200);
      tick;
    end
    ack(1'b1, 32'hCAFE_F00D);
    #1;
    chk("lw_rdy1", 32'(m_ready), 32'h1);
    tick;
    ack(1'b0, 32'h0);
    idle;
    chk("lw_pcw", pc_w, 32'h200);
    chk("lw_data", data_rd_w, 32'hCAFE_F00D);
    chk("lw_rd", 32'(rd_w), 32'd7);
    chk("add_pcm", pc_m, 32'h204);
    chk("add_alum", alu_m, 32'h0000_1234);
    tick;
    chk("add_pcw", pc_w, 32'h204);
    chk("add_data", data_rd_w, 32'h0000_1234);
    chk("add_rd", 32'(rd_w), 32'd8);

    // back-to-back ADDs, last with rd=0
    for (int i = 1; i <= 6; i++) begin
      op(1'b0, 1'b0, SZ_W, 1'b0, 1'b1,
         32'h300 + 32'(4 * i), 32'h100 + 32'(i),
         32'h0, (i == 6) ? 5'd0 : 5'(i));
      tick;
      if (i > 1) begin
        chk("b2b_wv", 32'(w_valid), 32'h1);
        chk("b2b_we", 32'(write_enable_w), 32'h1);
        chk("b2b_rd", 32'(rd_w), 32'(i - 1));
        chk("b2b_data", data_rd_w, 32'h100 + 32'(i - 1));
      end
    end
    idle;
    tick;
    chk("rd0_wv", 32'(w_valid), 32'h1);
    chk("rd0_we", 32'(write_enable_w), 32'h0);
    chk("rd0_data", data_rd_w, 32'h106);

    // reset while BUSY, late ack ignored
    op(1'b1, 1'b0, SZ_W, 1'b0, 1'b1,
       32'h400, 32'h0100_0010, 32'h0, 5'd9);
    tick;
    idle;
    #1;
    chk("rb_req0", 32'(dmem_req), 32'h1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    ack(1'b1, 32'h5555_5555);
    #1;
    chk("rb_req", 32'(dmem_req), 32'h0);
    chk("rb_rdy", 32'(m_ready), 32'h1);
    tick;
    ack(1'b0, 32'h0);
    chk("rb_wv", 32'(w_valid), 32'h0);
    chk("rb_we", 32'(write_enable_w), 32'h0);
    chk("rb_pcw", pc_w, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
